// File: rtl/efpga_cfg_pkg.sv
// Shared definitions for the eFPGA configuration-chain loader.
package efpga_cfg_pkg;

    localparam int unsigned DefWordW = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StShift = 2'd2,
        StDone  = 2'd3
    } ccff_state_e;

endpackage

// File: rtl/efpga_ccff_word_shifter.sv
// Holds one bitstream word and shifts it out LSB first, counting how many of its bits are live.
module efpga_ccff_word_shifter
    import efpga_cfg_pkg::*;
#(
    parameter int unsigned WORD_W = DefWordW,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic [CNT_W-1:0]  i_remaining,
    input  logic              i_shift,
    output logic              o_lsb,
    output logic              o_last
);

    localparam int unsigned BitsW = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] r_shifter;
    logic [BitsW-1:0]  r_word_bits;
    logic [BitsW-1:0]  w_bits;

    // A word never carries more bits than the chain still needs.
    always_comb begin
        w_bits = BitsW'(WORD_W);
        if (i_remaining < CNT_W'(WORD_W)) begin
            w_bits = BitsW'(i_remaining);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shifter   <= '0;
            r_word_bits <= '0;
        end else if (i_load) begin
            r_shifter   <= i_data;
            r_word_bits <= w_bits;
        end else if (i_shift) begin
            r_shifter   <= r_shifter >> 1;
            r_word_bits <= r_word_bits - BitsW'(1);
        end
    end

    assign o_lsb  = r_shifter[0];
    assign o_last = (r_word_bits == BitsW'(1));

endmodule

// File: rtl/efpga_ccff_loader.sv
// Streams bitstream words into a serial ccff chain under a gated chain clock and captures
// the bits returned from the chain tail.
module efpga_ccff_loader
    import efpga_cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 40,
    parameter int unsigned WORD_W    = DefWordW,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic              busy,
    output logic              done
);

    ccff_state_e       r_state;
    logic              r_cfg_ready;
    logic              r_head;
    logic              r_clk_en;
    logic [WORD_W-1:0] r_rb;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic              w_shift;
    logic              w_lsb;
    logic              w_last;
    logic [CNT_W-1:0]  w_remaining;
    logic [CNT_W-1:0]  w_bit_cnt_nxt;

    assign w_accept      = cfg_valid & r_cfg_ready;
    assign w_shift       = (r_state == StShift);
    assign w_remaining   = CNT_W'(CHAIN_LEN) - r_bit_cnt;
    assign w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);

    efpga_ccff_word_shifter #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_word_shifter (
        .i_clk       (prog_clk),
        .i_rst_n     (pReset_n),
        .i_load      (w_accept),
        .i_data      (cfg_data),
        .i_remaining (w_remaining),
        .i_shift     (w_shift),
        .o_lsb       (w_lsb),
        .o_last      (w_last)
    );

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_state     <= StIdle;
            r_cfg_ready <= 1'b0;
            r_head      <= 1'b0;
            r_clk_en    <= 1'b0;
            r_rb        <= '0;
            r_bit_cnt   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Readback follows the chain: it moves only on enabled chain edges.
            if (r_clk_en) begin
                r_rb <= {ccff_tail, r_rb[WORD_W-1:1]};
            end
            r_clk_en <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state     <= StLoad;
                        r_bit_cnt   <= '0;
                        r_done      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cfg_ready <= 1'b1;
                    end
                end
                StLoad: begin
                    if (w_accept) begin
                        r_state     <= StShift;
                        r_cfg_ready <= 1'b0;
                    end
                end
                StShift: begin
                    r_head    <= w_lsb;
                    r_clk_en  <= 1'b1;
                    r_bit_cnt <= w_bit_cnt_nxt;
                    if (w_last) begin
                        if (w_bit_cnt_nxt == CNT_W'(CHAIN_LEN)) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state     <= StLoad;
                            r_cfg_ready <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign cfg_ready   = r_cfg_ready;
    assign ccff_head   = r_head;
    assign ccff_clk_en = r_clk_en;
    assign rb_data     = r_rb;
    assign bit_cnt     = r_bit_cnt;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_efpga_ccff_loader.sv
// Directed bench for efpga_ccff_loader: a 40-bit and a 64-bit chain, each with a serial chain model.
module tb_efpga_ccff_loader;

    logic        prog_clk = 1'b0;
    logic        pReset_n = 1'b0;
    logic        start40  = 1'b0;
    logic        start64  = 1'b0;
    logic [31:0] cfg_data = '0;
    logic        cfg_valid = 1'b0;

    logic        ready40, head40, en40, busy40, done40, tail40;
    logic [31:0] rb40;
    logic [15:0] cnt40;
    logic        ready64, head64, en64, busy64, done64, tail64;
    logic [31:0] rb64;
    logic [15:0] cnt64;

    logic [39:0] chain40, pre40_val;
    logic [63:0] chain64, pre64_val;
    logic        pre40_req = 1'b0;
    logic        pre64_req = 1'b0;

    int total = 0;
    int bad = 0;
    int en_cnt40 = 0;
    int en_cnt64 = 0;
    int done_rise40 = 0;
    logic done_d40 = 1'b0;

    always #5 prog_clk = ~prog_clk;

    efpga_ccff_loader #(.CHAIN_LEN(40), .WORD_W(32), .CNT_W(16)) u_dut40 (
        .prog_clk    (prog_clk),
        .pReset_n    (pReset_n),
        .start       (start40),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (ready40),
        .ccff_head   (head40),
        .ccff_clk_en (en40),
        .ccff_tail   (tail40),
        .rb_data     (rb40),
        .bit_cnt     (cnt40),
        .busy        (busy40),
        .done        (done40)
    );

    efpga_ccff_loader #(.CHAIN_LEN(64), .WORD_W(32), .CNT_W(16)) u_dut64 (
        .prog_clk    (prog_clk),
        .pReset_n    (pReset_n),
        .start       (start64),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (ready64),
        .ccff_head   (head64),
        .ccff_clk_en (en64),
        .ccff_tail   (tail64),
        .rb_data     (rb64),
        .bit_cnt     (cnt64),
        .busy        (busy64),
        .done        (done64)
    );

    // Chain models: head enters at the top, tail leaves from bit 0.
    always @(posedge prog_clk) begin
        if (pre40_req) chain40 <= pre40_val;
        else if (en40) chain40 <= {head40, chain40[39:1]};
        if (pre64_req) chain64 <= pre64_val;
        else if (en64) chain64 <= {head64, chain64[63:1]};
    end
    assign tail40 = chain40[0];
    assign tail64 = chain64[0];

    always @(negedge prog_clk) begin
        if (en40) en_cnt40++;
        if (en64) en_cnt64++;
        if (done40 && !done_d40) done_rise40++;
        done_d40 = done40;
    end

    task automatic preload(input bit sel, input logic [63:0] v);
        @(negedge prog_clk);
        if (sel) begin pre64_val = v; pre64_req = 1'b1; end
        else begin pre40_val = v[39:0]; pre40_req = 1'b1; end
        @(negedge prog_clk);
        pre40_req = 1'b0;
        pre64_req = 1'b0;
    endtask

    task automatic do_start(input bit sel);
        @(negedge prog_clk);
        if (sel) start64 = 1'b1;
        else start40 = 1'b1;
        @(negedge prog_clk);
        start40 = 1'b0;
        start64 = 1'b0;
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w);
        int n;
        n = 0;
        cfg_data  = w;
        cfg_valid = 1'b1;
        while (!(sel ? ready64 : ready40) && n < 500) begin
            @(negedge prog_clk);
            n++;
        end
        total++;
        if (n >= 500) begin
            bad++;
            $display("FAIL send_word_timeout: cfg_ready=0 required 1 (word %h)", w);
        end
        @(negedge prog_clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        int n;
        n = 0;
        while (!(sel ? done64 : done40) && n < 500) begin
            @(negedge prog_clk);
            n++;
        end
        total++;
        if (n >= 500) begin
            bad++;
            $display("FAIL wait_done_timeout: done=0 required 1");
        end
        @(negedge prog_clk);
    endtask

    task automatic wait_cnt40(input logic [15:0] v);
        int n;
        n = 0;
        while (cnt40 !== v && n < 500) begin
            @(negedge prog_clk);
            n++;
        end
        total++;
        if (n >= 500) begin
            bad++;
            $display("FAIL wait_bit_cnt: bit_cnt=%0d required %0d", cnt40, v);
        end
    endtask

    task automatic check_finish40(input string name, input logic [39:0] exp_chain);
        total++;
        if (en_cnt40 !== 40) begin
            bad++;
            $display("FAIL %s_enables: got %0d required 40", name, en_cnt40);
        end
        total++;
        if (cnt40 !== 16'd40 || done40 !== 1'b1 || busy40 !== 1'b0) begin
            bad++;
            $display("FAIL %s_status: bit_cnt=%0d done=%b busy=%b required 40 1 0",
                     name, cnt40, done40, busy40);
        end
        total++;
        if (chain40 !== exp_chain) begin
            bad++;
            $display("FAIL %s_stream: chain=%h required %h", name, chain40, exp_chain);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge prog_clk);
        total++;
        if ({ready40, head40, en40, busy40, done40, cnt40, rb40} !== '0) begin
            bad++;
            $display("FAIL reset_state: rdy=%b head=%b en=%b busy=%b done=%b cnt=%0d rb=%h required all 0",
                     ready40, head40, en40, busy40, done40, cnt40, rb40);
        end
        pReset_n = 1'b1;
        repeat (2) @(negedge prog_clk);
        total++;
        if ({ready40, en40, busy40, ready64, en64, busy64} !== '0) begin
            bad++;
            $display("FAIL idle_after_reset: rdy=%b en=%b busy=%b required 0 0 0", ready40, en40, busy40);
        end
    endtask

    task automatic test_nominal;
        en_cnt40 = 0;
        do_start(1'b0);
        total++;
        if (busy40 !== 1'b1 || ready40 !== 1'b1 || done40 !== 1'b0) begin
            bad++;
            $display("FAIL start_accept: busy=%b ready=%b done=%b required 1 1 0", busy40, ready40, done40);
        end
        send_word(1'b0, 32'hA5A5A5A5);
        send_word(1'b0, 32'h000000C3);
        wait_done(1'b0);
        check_finish40("nominal", 40'hC3A5A5A5A5);
        repeat (3) @(negedge prog_clk);
        total++;
        if (done40 !== 1'b1 || busy40 !== 1'b0 || en_cnt40 !== 40) begin
            bad++;
            $display("FAIL done_hold: done=%b busy=%b enables=%0d required 1 0 40", done40, busy40, en_cnt40);
        end
    endtask

    task automatic test_stall;
        int low;
        low = 0;
        en_cnt40 = 0;
        do_start(1'b0);
        send_word(1'b0, 32'hA5A5A5A5);
        while (!ready40 && low < 100) begin
            @(negedge prog_clk);
            low++;
        end
        low = 0;
        repeat (5) begin
            @(negedge prog_clk);
            if (en40 === 1'b0 && cnt40 === 16'd32 && head40 === 1'b1 && ready40 === 1'b1) low++;
        end
        total++;
        if (low !== 5) begin
            bad++;
            $display("FAIL stall_hold: frozen cycles=%0d required 5 (cnt=%0d en=%b)", low, cnt40, en40);
        end
        send_word(1'b0, 32'h000000C3);
        wait_done(1'b0);
        check_finish40("stall", 40'hC3A5A5A5A5);
    endtask

    task automatic test_readback;
        preload(1'b0, {24'h0, 32'hDEADBEEF, 8'h5A});
        en_cnt40 = 0;
        do_start(1'b0);
        send_word(1'b0, 32'hA5A5A5A5);
        send_word(1'b0, 32'hFFFFFFC3);
        wait_done(1'b0);
        check_finish40("truncate", 40'hC3A5A5A5A5);
        total++;
        if (rb40 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL readback: rb_data=%h required deadbeef", rb40);
        end
    endtask

    task automatic test_reset_midload;
        int e;
        do_start(1'b0);
        send_word(1'b0, 32'h12345678);
        wait_cnt40(16'd17);
        #2 pReset_n = 1'b0;
        #1;
        total++;
        if ({ready40, head40, en40, busy40, done40, cnt40, rb40} !== '0) begin
            bad++;
            $display("FAIL reset_midload: rdy=%b head=%b en=%b busy=%b done=%b cnt=%0d rb=%h required all 0",
                     ready40, head40, en40, busy40, done40, cnt40, rb40);
        end
        e = en_cnt40;
        repeat (3) @(negedge prog_clk);
        total++;
        if (en_cnt40 !== e) begin
            bad++;
            $display("FAIL reset_no_enables: enables=%0d required %0d", en_cnt40, e);
        end
        pReset_n = 1'b1;
        @(negedge prog_clk);
        en_cnt40 = 0;
        do_start(1'b0);
        send_word(1'b0, 32'hA5A5A5A5);
        send_word(1'b0, 32'h000000C3);
        wait_done(1'b0);
        check_finish40("after_reset", 40'hC3A5A5A5A5);
    endtask

    task automatic test_start_during_shift;
        en_cnt40 = 0;
        done_rise40 = 0;
        do_start(1'b0);
        send_word(1'b0, 32'hA5A5A5A5);
        wait_cnt40(16'd5);
        start40 = 1'b1;
        @(negedge prog_clk);
        start40 = 1'b0;
        send_word(1'b0, 32'h000000C3);
        wait_done(1'b0);
        check_finish40("start_ignored", 40'hC3A5A5A5A5);
        repeat (4) @(negedge prog_clk);
        total++;
        if (done_rise40 !== 1 || busy40 !== 1'b0 || en_cnt40 !== 40) begin
            bad++;
            $display("FAIL single_done: done rises=%0d busy=%b enables=%0d required 1 0 40",
                     done_rise40, busy40, en_cnt40);
        end
    endtask

    task automatic test_chain64;
        preload(1'b1, {32'hCAFEF00D, 32'h0});
        en_cnt64 = 0;
        do_start(1'b1);
        send_word(1'b1, 32'h12345678);
        send_word(1'b1, 32'h9ABCDEF0);
        wait_done(1'b1);
        total++;
        if (en_cnt64 !== 64 || cnt64 !== 16'd64 || done64 !== 1'b1) begin
            bad++;
            $display("FAIL chain64_count: enables=%0d bit_cnt=%0d done=%b required 64 64 1",
                     en_cnt64, cnt64, done64);
        end
        total++;
        if (chain64 !== 64'h9ABCDEF0_12345678) begin
            bad++;
            $display("FAIL chain64_stream: chain=%h required 9abcdef012345678", chain64);
        end
        total++;
        if (rb64 !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL chain64_readback: rb_data=%h required cafef00d", rb64);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_readback();
        test_reset_midload();
        test_start_during_shift();
        test_chain64();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
